// File: rtl/vector_register_scoreboard_if.sv
// Issue/writeback/flags bus of the vector register scoreboard.
// The master side drives requests; the slave side is the register file.
interface vector_register_scoreboard_if #(
  parameter int NUM_REGS = 16,
  parameter int LANES    = 4,
  parameter int LANE_W   = 64,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int FLAGS_W  = 64
);
  localparam int RID_W = $clog2(NUM_REGS);
  localparam int VEC_W = LANES * LANE_W;

  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*RID_W-1:0]  rd_id;
  logic [NUM_RD*VEC_W-1:0]  rd_data;
  logic [NUM_RD-1:0]        rd_ready;
  logic                     inv_en;
  logic [RID_W-1:0]         inv_id;
  logic                     inv_ready;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*RID_W-1:0]  wr_id;
  logic [NUM_WR*LANES-1:0]  wr_mask;
  logic [NUM_WR*VEC_W-1:0]  wr_data;
  logic [NUM_REGS-1:0]      reg_ready;
  logic [FLAGS_W-1:0]       flag_set;
  logic [FLAGS_W-1:0]       flag_clr;
  logic [FLAGS_W-1:0]       flags;
  logic                     halted;
  logic                     err_wr_conflict;
  logic                     err_spurious_wr;

  modport master (
    output rd_en, rd_id, inv_en, inv_id, wr_en, wr_id, wr_mask, wr_data, flag_set, flag_clr,
    input  rd_data, rd_ready, inv_ready, reg_ready, flags, halted, err_wr_conflict, err_spurious_wr
  );

  modport slave (
    input  rd_en, rd_id, inv_en, inv_id, wr_en, wr_id, wr_mask, wr_data, flag_set, flag_clr,
    output rd_data, rd_ready, inv_ready, reg_ready, flags, halted, err_wr_conflict, err_spurious_wr
  );
endinterface

// File: rtl/vector_register_scoreboard.sv
// Multi-port vector register file with per-register issue/retire scoreboard,
// write-first read forwarding and a machine-flags register.
module vector_register_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int LANES    = 4,
  parameter int LANE_W   = 64,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int CNT_W    = 8,
  parameter int FLAGS_W  = 64,
  parameter int HALT_BIT = 0
) (
  input logic clk,
  input logic reset,
  vector_register_scoreboard_if.slave bus
);
  localparam int RID_W = $clog2(NUM_REGS);
  localparam int VEC_W = LANES * LANE_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [VEC_W-1:0]        regs_r       [NUM_REGS];
  logic [CNT_W-1:0]        issue_cnt_r  [NUM_REGS];
  logic [CNT_W-1:0]        retire_cnt_r [NUM_REGS];
  logic [FLAGS_W-1:0]      flags_r;
  logic [NUM_RD*VEC_W-1:0] rd_data_r;
  logic [NUM_RD-1:0]       rd_ready_r;
  logic                    err_wr_conflict_r;
  logic                    err_spurious_wr_r;

  logic [VEC_W-1:0]        regs_nxt_s   [NUM_REGS];
  logic [CNT_W-1:0]        issue_nxt_s  [NUM_REGS];
  logic [CNT_W-1:0]        retire_nxt_s [NUM_REGS];
  logic [CNT_W-1:0]        outst_s      [NUM_REGS];
  logic [NUM_REGS-1:0]     reg_ready_s;
  logic                    inv_ready_s;
  logic                    conflict_s;
  logic                    spurious_s;
  logic [NUM_RD*VEC_W-1:0] rd_data_nxt_s;
  logic [NUM_RD-1:0]       rd_ready_nxt_s;

  // Outstanding-write count per register and the reservation handshake.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      outst_s[r]     = issue_cnt_r[r] - retire_cnt_r[r];
      reg_ready_s[r] = (outst_s[r] == '0);
    end
    inv_ready_s = bus.inv_en && !flags_r[HALT_BIT] && (outst_s[bus.inv_id] != CNT_MAX);
  end

  // Merge writeback ports into next register state and advance both counters.
  always_comb begin
    logic [CNT_W:0] hits_v;
    logic [CNT_W:0] avail_v;
    logic [CNT_W:0] inc_v;
    logic           hit_v;
    logic           inv_hit_v;
    conflict_s = 1'b0;
    spurious_s = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      hits_v        = '0;
      regs_nxt_s[r] = regs_r[r];
      // Ascending port order lets the highest-index port overwrite each lane.
      for (int p = 0; p < NUM_WR; p++) begin
        hit_v  = bus.wr_en[p] && (bus.wr_id[p*RID_W +: RID_W] == RID_W'(r));
        hits_v = hits_v + {{CNT_W{1'b0}}, hit_v};
        for (int l = 0; l < LANES; l++) begin
          regs_nxt_s[r][l*LANE_W +: LANE_W] = (hit_v && bus.wr_mask[p*LANES + l]) ?
              bus.wr_data[p*VEC_W + l*LANE_W +: LANE_W] : regs_nxt_s[r][l*LANE_W +: LANE_W];
        end
      end
      inv_hit_v = inv_ready_s && (bus.inv_id == RID_W'(r));
      avail_v   = {1'b0, outst_s[r]} + {{CNT_W{1'b0}}, inv_hit_v};
      if (hits_v == '0) begin
        inc_v = '0;
      end else if (outst_s[r] == '0) begin
        inc_v      = '0;
        spurious_s = 1'b1;
      end else begin
        inc_v = (hits_v > avail_v) ? avail_v : hits_v;
      end
      conflict_s      = conflict_s || (hits_v > (CNT_W+1)'(1));
      issue_nxt_s[r]  = issue_cnt_r[r] + {{(CNT_W-1){1'b0}}, inv_hit_v};
      retire_nxt_s[r] = retire_cnt_r[r] + inc_v[CNT_W-1:0];
    end
  end

  // Read ports see this cycle's writes; an idle port keeps its last result.
  always_comb begin
    logic [RID_W-1:0] id_v;
    for (int q = 0; q < NUM_RD; q++) begin
      id_v = bus.rd_id[q*RID_W +: RID_W];
      rd_data_nxt_s[q*VEC_W +: VEC_W] = bus.rd_en[q] ? regs_nxt_s[id_v] : rd_data_r[q*VEC_W +: VEC_W];
      rd_ready_nxt_s[q] = bus.rd_en[q] ? (issue_nxt_s[id_v] == retire_nxt_s[id_v]) : rd_ready_r[q];
    end
  end

  // State update; reset discards anything presented on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_r[r]       <= '0;
        issue_cnt_r[r]  <= '0;
        retire_cnt_r[r] <= '0;
      end
      flags_r           <= '0;
      rd_data_r         <= '0;
      rd_ready_r        <= '0;
      err_wr_conflict_r <= 1'b0;
      err_spurious_wr_r <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_r[r]       <= regs_nxt_s[r];
        issue_cnt_r[r]  <= issue_nxt_s[r];
        retire_cnt_r[r] <= retire_nxt_s[r];
      end
      flags_r           <= (flags_r & ~bus.flag_clr) | bus.flag_set;
      rd_data_r         <= rd_data_nxt_s;
      rd_ready_r        <= rd_ready_nxt_s;
      err_wr_conflict_r <= conflict_s;
      err_spurious_wr_r <= spurious_s;
    end
  end

  assign bus.rd_data         = rd_data_r;
  assign bus.rd_ready        = rd_ready_r;
  assign bus.inv_ready       = inv_ready_s;
  assign bus.reg_ready       = reg_ready_s;
  assign bus.flags           = flags_r;
  assign bus.halted          = flags_r[HALT_BIT];
  assign bus.err_wr_conflict = err_wr_conflict_r;
  assign bus.err_spurious_wr = err_spurious_wr_r;
endmodule

// File: tb/tb_vector_register_scoreboard.sv
// Self-checking bench: behavioural model predicts each cycle, read results are
// queued at issue and compared when the registered outputs appear.
module tb_vector_register_scoreboard;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  vector_register_scoreboard_if bus ();

  vector_register_scoreboard dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           port;
    logic [255:0] data;
    logic         ready;
  } rd_exp_t;

  rd_exp_t      rdq [$];
  logic [255:0] m_regs [16];
  logic [7:0]   m_iss  [16];
  logic [7:0]   m_ret  [16];
  logic [63:0]  m_flags;
  logic         exp_conf;
  logic         exp_sp;

  localparam logic [63:0] LA = 64'hAAAA_0000_0000_000A;
  localparam logic [63:0] LB = 64'hBBBB_0000_0000_000B;
  localparam logic [63:0] LC = 64'hCCCC_0000_0000_000C;
  localparam logic [63:0] LD = 64'hDDDD_0000_0000_000D;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    bus.rd_en    = '0;
    bus.rd_id    = '0;
    bus.inv_en   = 1'b0;
    bus.inv_id   = '0;
    bus.wr_en    = '0;
    bus.wr_id    = '0;
    bus.wr_mask  = '0;
    bus.wr_data  = '0;
    bus.flag_set = '0;
    bus.flag_clr = '0;
  endtask

  task automatic rd(input int q, input int id);
    bus.rd_en[q]       = 1'b1;
    bus.rd_id[q*4 +: 4] = 4'(id);
  endtask

  task automatic inv(input int id);
    bus.inv_en = 1'b1;
    bus.inv_id = 4'(id);
  endtask

  task automatic wr(input int p, input int id, input logic [3:0] m, input logic [255:0] d);
    bus.wr_en[p]            = 1'b1;
    bus.wr_id[p*4 +: 4]     = 4'(id);
    bus.wr_mask[p*4 +: 4]   = m;
    bus.wr_data[p*256 +: 256] = d;
  endtask

  // One clock: check combinational outputs, predict, clock, compare registered outputs.
  task automatic cycle();
    logic [7:0]   outst [16];
    logic [255:0] nregs [16];
    logic [15:0]  exp_rr;
    logic         exp_inv;
    int           hits;
    int           avail;
    int           inc;
    int           id;
    logic         inv_hit;
    rd_exp_t      e;
    #2;
    for (int r = 0; r < 16; r++) begin
      outst[r]  = m_iss[r] - m_ret[r];
      exp_rr[r] = (outst[r] == 8'd0);
      nregs[r]  = m_regs[r];
    end
    exp_inv = bus.inv_en && !m_flags[0] && (outst[bus.inv_id] != 8'hFF);
    check_eq("reg_ready", 256'(bus.reg_ready), 256'(exp_rr));
    check_eq("inv_ready", 256'(bus.inv_ready), 256'(exp_inv));
    for (int p = 0; p < 2; p++) begin
      if (bus.wr_en[p]) begin
        id = int'(bus.wr_id[p*4 +: 4]);
        for (int l = 0; l < 4; l++)
          if (bus.wr_mask[p*4 + l]) nregs[id][l*64 +: 64] = bus.wr_data[p*256 + l*64 +: 64];
      end
    end
    exp_conf = (bus.wr_en == 2'b11) && (bus.wr_id[3:0] == bus.wr_id[7:4]);
    exp_sp   = 1'b0;
    for (int r = 0; r < 16; r++) begin
      hits = 0;
      for (int p = 0; p < 2; p++)
        if (bus.wr_en[p] && int'(bus.wr_id[p*4 +: 4]) == r) hits++;
      inv_hit = exp_inv && (int'(bus.inv_id) == r);
      avail   = int'(outst[r]) + (inv_hit ? 1 : 0);
      inc     = 0;
      if (hits > 0 && outst[r] == 8'd0) exp_sp = 1'b1;
      else if (hits > 0) inc = (hits < avail) ? hits : avail;
      m_iss[r]  = m_iss[r] + (inv_hit ? 8'd1 : 8'd0);
      m_ret[r]  = m_ret[r] + 8'(inc);
      m_regs[r] = nregs[r];
    end
    m_flags = (m_flags & ~bus.flag_clr) | bus.flag_set;
    for (int q = 0; q < 2; q++) begin
      if (bus.rd_en[q]) begin
        id      = int'(bus.rd_id[q*4 +: 4]);
        e.port  = q;
        e.data  = m_regs[id];
        e.ready = (m_iss[id] == m_ret[id]);
        rdq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check_eq("err_wr_conflict", 256'(bus.err_wr_conflict), 256'(exp_conf));
    check_eq("err_spurious_wr", 256'(bus.err_spurious_wr), 256'(exp_sp));
    check_eq("flags", 256'(bus.flags), 256'(m_flags));
    check_eq("halted", 256'(bus.halted), 256'(m_flags[0]));
    while (rdq.size() > 0) begin
      e = rdq.pop_front();
      check_eq("rd_data", bus.rd_data[e.port*256 +: 256], e.data);
      check_eq("rd_ready", 256'(bus.rd_ready[e.port]), 256'(e.ready));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int r = 0; r < 16; r++) begin
      m_regs[r] = '0;
      m_iss[r]  = 8'd0;
      m_ret[r]  = 8'd0;
    end
    m_flags = 64'd0;
    rdq.delete();
    check_eq("rst_rd_data", bus.rd_data, 512'd0);
    check_eq("rst_rd_ready", 256'(bus.rd_ready), 256'd0);
    check_eq("rst_flags", 256'(bus.flags), 256'd0);
    check_eq("rst_err", 256'({bus.err_wr_conflict, bus.err_spurious_wr}), 256'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    do_reset();

    // Read after reset.
    rd(0, 3); cycle(); idle();
    check_eq("rst_read_r3", bus.rd_data[255:0], 256'd0);
    check_eq("rst_read_ready", 256'(bus.rd_ready[0]), 256'd1);
    #1 check_eq("rst_reg_ready", 256'(bus.reg_ready), 256'(16'hFFFF));

    // Reserve r5, then masked writeback.
    inv(5); cycle(); idle();
    wr(0, 5, 4'b0101, {LD, LC, LB, LA});
    #1 check_eq("r5_pending", 256'(bus.reg_ready[5]), 256'd0);
    cycle(); idle();
    rd(0, 5); cycle(); idle();
    check_eq("r5_masked", bus.rd_data[255:0], {64'd0, LC, 64'd0, LA});

    // Two ports write r2 in the same cycle after two reservations.
    inv(2); cycle(); idle();
    inv(2); cycle(); idle();
    wr(0, 2, 4'hF, {4{LA}}); wr(1, 2, 4'hF, {4{LB}}); cycle(); idle();
    check_eq("conflict_pulse", 256'(bus.err_wr_conflict), 256'd1);
    rd(1, 2); cycle(); idle();
    check_eq("conflict_winner", bus.rd_data[511:256], {4{LB}});
    check_eq("conflict_ready", 256'(bus.rd_ready[1]), 256'd1);
    check_eq("conflict_oneshot", 256'(bus.err_wr_conflict), 256'd0);

    // Saturate r7's outstanding count.
    for (int i = 0; i < 255; i++) begin
      inv(7); cycle(); idle();
    end
    inv(7);
    #1 check_eq("sat_inv_ready", 256'(bus.inv_ready), 256'd0);
    cycle(); idle();
    check_eq("sat_reg_ready7", 256'(bus.reg_ready[7]), 256'd0);
    wr(0, 7, 4'hF, {4{LC}}); cycle(); idle();
    inv(7);
    #1 check_eq("unsat_inv_ready", 256'(bus.inv_ready), 256'd1);
    cycle(); idle();

    // Write-first forwarding on r4, then a spurious write to idle r9.
    inv(4); cycle(); idle();
    wr(1, 4, 4'hF, {LD, LC, LB, LA}); rd(1, 4); cycle(); idle();
    check_eq("fwd_data", bus.rd_data[511:256], {LD, LC, LB, LA});
    check_eq("fwd_ready", 256'(bus.rd_ready[1]), 256'd1);
    wr(0, 9, 4'hF, {4{LD}}); cycle(); idle();
    check_eq("spurious_pulse", 256'(bus.err_spurious_wr), 256'd1);
    rd(0, 9); cycle(); idle();
    check_eq("spurious_data", bus.rd_data[255:0], {4{LD}});

    // Same-cycle reserve and retire, then clamped double retire.
    inv(6); cycle(); idle();
    inv(6); wr(0, 6, 4'hF, {4{LA}}); cycle(); idle();
    #1 check_eq("inv_wr_net", 256'(bus.reg_ready[6]), 256'd0);
    wr(0, 6, 4'hF, {4{LB}}); wr(1, 6, 4'b0011, {4{LC}}); cycle(); idle();
    check_eq("clamp_conflict", 256'(bus.err_wr_conflict), 256'd1);
    check_eq("clamp_not_spurious", 256'(bus.err_spurious_wr), 256'd0);
    #1 check_eq("clamp_ready", 256'(bus.reg_ready[6]), 256'd1);
    rd(0, 6); cycle(); idle();
    check_eq("clamp_data", bus.rd_data[255:0], {LB, LB, LC, LC});

    // Empty mask still retires.
    inv(8); cycle(); idle();
    wr(1, 8, 4'h0, {4{LD}}); cycle(); idle();
    rd(0, 8); cycle(); idle();
    check_eq("mask0_data", bus.rd_data[255:0], 256'd0);
    check_eq("mask0_ready", 256'(bus.rd_ready[0]), 256'd1);

    // Flags: set wins over clear; halt blocks reservations only.
    bus.flag_set = 64'h0000_0000_0000_00F1; bus.flag_clr = 64'h0000_0000_0000_0001; cycle(); idle();
    check_eq("halt_set", 256'(bus.halted), 256'd1);
    bus.flag_clr = 64'h0000_0000_0000_0010; cycle(); idle();
    check_eq("flags_clr", 256'(bus.flags), 256'(64'h0000_0000_0000_00E1));
    inv(3);
    #1 check_eq("halt_inv_ready", 256'(bus.inv_ready), 256'd0);
    cycle(); idle();
    wr(0, 7, 4'hF, {4{LA}}); rd(1, 7); cycle(); idle();
    check_eq("halt_drain", bus.rd_data[511:256], {4{LA}});
    do_reset();
    check_eq("reset_halted", 256'(bus.halted), 256'd0);

    // Reset while a write is presented: the write is dropped.
    inv(1); cycle(); idle();
    wr(0, 1, 4'hF, {4{LD}});
    do_reset(); idle();
    rd(0, 1); cycle(); idle();
    check_eq("reset_drop", bus.rd_data[255:0], 256'd0);
    check_eq("reset_ready", 256'(bus.rd_ready[0]), 256'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
